// File: rtl/core_pkg.sv
// Shared lane types: request payload, instruction IDs, VRF data word and VFU enumeration.
package core_pkg;

    localparam int unsigned NrLaneVFU = 2;
    localparam int unsigned InsnIDNum = 8;

    typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;
    typedef logic [63:0]                  vrf_data_t;

    typedef enum logic [1:0] {
        VFU_ALU,
        VFU_MFPU,
        VFU_SLDU,
        VFU_LD
    } vfu_e;

    typedef struct packed {
        insn_id_t    id;
        vfu_e        vfu;
        logic [15:0] op;
    } vfu_req_t;

endpackage

// File: rtl/lane_req_fifo.sv
// Power-of-two depth request FIFO with valid/ready on both sides; storage is not reset.
module lane_req_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_valid_i,
    output logic push_ready_o,
    input  T     push_data_i,
    output logic pop_valid_o,
    input  logic pop_ready_i,
    output T     pop_data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] DepthC = Depth[AW:0];

    T              mem_q [Depth];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          push, pop;

    assign full_o       = (cnt_q == DepthC);
    assign empty_o      = (cnt_q == '0);
    assign push_ready_o = !full_o;
    assign pop_valid_o  = !empty_o;
    assign pop_data_o   = mem_q[rd_q];

    assign push = push_valid_i && push_ready_o;
    assign pop  = pop_valid_o && pop_ready_i;

    // Pointers are exactly log2(Depth) bits wide, so increment wraps on its own.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/lane_vfu_hub.sv
// Launcher-to-VFU request fan-out, round-robin completion merge and store-operand path.
// Store path is a 2-entry skid buffer when LANE_STORE_SKID_EN is defined, else a wire.
module lane_vfu_hub
    import core_pkg::*;
#(
    parameter  int unsigned NrVfu    = NrLaneVFU,
    parameter  int unsigned ReqDepth = 2,
    localparam int unsigned TgtW     = $clog2(NrVfu)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  vfu_req_t                 req_i,
    input  logic [TgtW-1:0]          target_vfu_i,
    output logic                     illegal_tgt_o,
    output logic [NrVfu-1:0]         vfu_req_valid_o,
    input  logic [NrVfu-1:0]         vfu_req_ready_i,
    output vfu_req_t [NrVfu-1:0]     vfu_req_o,
    input  logic [NrVfu-1:0]         vfu_done_i,
    input  insn_id_t [NrVfu-1:0]     vfu_done_id_i,
    output logic [NrVfu-1:0]         vfu_done_gnt_o,
    output logic                     done_valid_o,
    output insn_id_t                 done_id_o,
    output logic [TgtW-1:0]          done_vfu_o,
    input  logic                     done_ready_i,
    input  logic                     st_valid_i,
    output logic                     st_ready_o,
    input  vrf_data_t                st_op_i,
    output logic                     st_valid_o,
    input  logic                     st_ready_i,
    output vrf_data_t                st_op_o
);

    localparam int unsigned TgtSpan = 1 << TgtW;
    localparam logic [TgtW:0]   NrVfuW  = NrVfu[TgtW:0];
    localparam logic [TgtW-1:0] LastVfu = TgtW'(NrVfu - 1);

    typedef logic [TgtW:0] idxw_t;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    logic [NrVfu-1:0]   fifo_full, fifo_empty, fifo_push_ready, fifo_push_valid;
    logic [TgtSpan-1:0] full_ext, tgt_legal;
    vfu_req_t           fifo_head [NrVfu];
    logic               illegal_q;

    // Target codes past NrVfu look "never full" so the launcher is never stalled by them.
    for (genvar t = 0; t < TgtSpan; t++) begin : g_tgt
        if (t < NrVfu) begin : g_real
            assign full_ext[t]  = fifo_full[t];
            assign tgt_legal[t] = 1'b1;
        end else begin : g_pad
            assign full_ext[t]  = 1'b0;
            assign tgt_legal[t] = 1'b0;
        end
    end

    assign req_ready_o   = !full_ext[target_vfu_i];
    assign illegal_tgt_o = illegal_q;

    for (genvar i = 0; i < NrVfu; i++) begin : g_fifo
        assign fifo_push_valid[i] = req_valid_i && (target_vfu_i == TgtW'(i)) && fifo_push_ready[i];

        lane_req_fifo #(
            .T     (vfu_req_t),
            .Depth (ReqDepth)
        ) i_fifo (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .push_valid_i (fifo_push_valid[i]),
            .push_ready_o (fifo_push_ready[i]),
            .push_data_i  (req_i),
            .pop_valid_o  (vfu_req_valid_o[i]),
            .pop_ready_i  (vfu_req_ready_i[i]),
            .pop_data_o   (fifo_head[i]),
            .full_o       (fifo_full[i]),
            .empty_o      (fifo_empty[i])
        );

        assign vfu_req_o[i] = fifo_empty[i] ? '0 : fifo_head[i];
    end

    // ------------------------------------------------------------------
    // Completion arbiter and output register
    // ------------------------------------------------------------------
    logic            done_valid_q;
    insn_id_t        done_id_q;
    logic [TgtW-1:0] done_vfu_q, rr_q, rr_d, done_win;
    logic            done_free, done_any;
    logic [NrVfu-1:0] done_gnt;
    idxw_t           idx_w;
    logic [TgtW-1:0] idx;

    assign done_free = !done_valid_q || done_ready_i;

    always_comb begin
        done_gnt = '0;
        done_win = '0;
        done_any = 1'b0;
        idx_w    = '0;
        idx      = '0;
        if (done_free) begin
            for (int k = 0; k < NrVfu; k++) begin
                idx_w = {1'b0, rr_q} + idxw_t'(k);
                if (idx_w >= NrVfuW) idx_w = idx_w - NrVfuW;
                idx = idx_w[TgtW-1:0];
                if (!done_any && vfu_done_i[idx]) begin
                    done_any      = 1'b1;
                    done_win      = idx;
                    done_gnt[idx] = 1'b1;
                end
            end
        end
        rr_d = (done_win == LastVfu) ? '0 : done_win + 1'b1;
    end

    assign vfu_done_gnt_o = done_gnt;
    assign done_valid_o   = done_valid_q;
    assign done_id_o      = done_id_q;
    assign done_vfu_o     = done_vfu_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            done_vfu_q   <= '0;
            rr_q         <= '0;
            illegal_q    <= 1'b0;
        end else begin
            illegal_q <= req_valid_i && !tgt_legal[target_vfu_i];
            if (done_free) begin
                done_valid_q <= done_any;
                if (done_any) begin
                    done_id_q  <= vfu_done_id_i[done_win];
                    done_vfu_q <= done_win;
                    rr_q       <= rr_d;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Store-operand path
    // ------------------------------------------------------------------
`ifdef LANE_STORE_SKID_EN
    logic [1:0] st_cnt_q, st_cnt_d;
    logic       st_valid_q, st_ready_q, st_push, st_pop;
    vrf_data_t  st_head_q, st_tail_q;

    assign st_push    = st_valid_i && st_ready_q;
    assign st_pop     = st_valid_q && st_ready_i;
    assign st_cnt_d   = st_cnt_q + {1'b0, st_push} - {1'b0, st_pop};
    assign st_valid_o = st_valid_q;
    assign st_ready_o = st_ready_q;
    assign st_op_o    = st_head_q;

    // Both handshake flags come from the next occupancy, so neither output sees st_ready_i combinationally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_cnt_q   <= '0;
            st_valid_q <= 1'b0;
            st_ready_q <= 1'b1;
        end else begin
            st_cnt_q   <= st_cnt_d;
            st_valid_q <= (st_cnt_d != 2'd0);
            st_ready_q <= (st_cnt_d != 2'd2);
        end
    end

    always_ff @(posedge clk_i) begin
        if (st_pop) begin
            if (st_cnt_q == 2'd2) st_head_q <= st_tail_q;
            else if (st_push)     st_head_q <= st_op_i;
        end else if (st_push) begin
            if (st_cnt_q == 2'd0) st_head_q <= st_op_i;
            else                  st_tail_q <= st_op_i;
        end
    end
`else
    assign st_valid_o = st_valid_i;
    assign st_op_o    = st_op_i;
    assign st_ready_o = st_ready_i;
`endif

endmodule
